// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampling UART receiver.
// Includes the receiver FSM state encoding, parity mode constants and the 3-sample majority vote.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } uart_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Oversample tick generator: one-clk tick every CLK_DIV clocks.
// i_clr restarts the count so bit phase can be aligned to a start edge.
module uart_os_tick #(
  parameter int CLK_DIV = 27
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || (r_cnt == CW'(CLK_DIV - 1))) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = (r_cnt == CW'(CLK_DIV - 1));

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with 3-sample majority voting, optional parity,
// one or two stop bits and a valid/ready output register.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int CLK_DIV     = 27,
  parameter int OS          = 16,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_valid,
  input  logic                 i_rx_ready,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_overrun,
  output logic                 o_busy
);

  localparam int OSW        = $clog2(OS);
  localparam int FRAME_BITS = 1 + DATA_BITS + ((PARITY != PAR_NONE) ? 1 : 0) + STOP_BITS;
  localparam int BCW        = $clog2(FRAME_BITS);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_rx_prev;
  uart_state_e            r_state;
  logic [OSW-1:0]         r_os;
  logic [1:0]             r_smp;
  logic [BCW-1:0]         r_bitcnt;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_par_err;
  logic                   r_busy;
  logic                   r_frame_err;
  logic                   r_deliver;
  logic [DATA_BITS-1:0]   r_rx_data;
  logic                   r_rx_valid;
  logic                   r_parity_err;
  logic                   r_overrun;

  logic w_rx_s;
  logic w_start_edge;
  logic w_tick;
  logic w_mid;
  logic w_end;
  logic w_bit;
  logic w_par_exp;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync    <= '1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], i_rx};
      r_rx_prev <= w_rx_s;
    end
  end

  assign w_rx_s       = r_sync[SYNC_STAGES-1];
  assign w_start_edge = (r_state == IDLE) && r_rx_prev && !w_rx_s;

  uart_os_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_clr  (w_start_edge),
    .o_tick (w_tick)
  );

  // Decision uses the two stored samples plus the live third sample.
  assign w_mid     = w_tick && (r_os == OSW'(OS / 2 + 1));
  assign w_end     = w_tick && (r_os == OSW'(OS - 1));
  assign w_bit     = maj3(r_smp[0], r_smp[1], w_rx_s);
  assign w_par_exp = (PARITY == PAR_ODD) ? ~(^r_shift) : (^r_shift);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_os        <= '0;
      r_smp       <= 2'b11;
      r_bitcnt    <= '0;
      r_shift     <= '0;
      r_par_err   <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_err <= 1'b0;
      r_deliver   <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      r_deliver   <= 1'b0;
      if (w_tick && (r_state != IDLE)) begin
        r_os <= (r_os == OSW'(OS - 1)) ? '0 : r_os + 1'b1;
        if (r_os == OSW'(OS / 2 - 1)) r_smp[0] <= w_rx_s;
        if (r_os == OSW'(OS / 2))     r_smp[1] <= w_rx_s;
      end
      case (r_state)
        IDLE: begin
          if (w_start_edge) begin
            r_state   <= START;
            r_busy    <= 1'b1;
            r_os      <= '0;
            r_bitcnt  <= '0;
            r_par_err <= 1'b0;
          end
        end
        START: begin
          if (w_mid && w_bit) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (w_end) begin
            r_state <= DATA;
          end
        end
        DATA: begin
          if (w_mid) r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
          if (w_end) begin
            if (r_bitcnt == BCW'(DATA_BITS - 1)) begin
              r_bitcnt <= '0;
              r_state  <= (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
            end else begin
              r_bitcnt <= r_bitcnt + 1'b1;
            end
          end
        end
        uart_pkg::PARITY: begin
          if (w_mid) r_par_err <= (w_bit != w_par_exp);
          if (w_end) r_state <= STOP;
        end
        // Leave for IDLE on the last stop decision so a new start edge is caught mid stop-bit.
        STOP: begin
          if (w_mid) begin
            if (!w_bit) begin
              r_frame_err <= 1'b1;
              r_state     <= BREAK;
            end else if (r_bitcnt == BCW'(STOP_BITS - 1)) begin
              r_state   <= IDLE;
              r_busy    <= 1'b0;
              r_deliver <= 1'b1;
            end
          end else if (w_end) begin
            r_bitcnt <= r_bitcnt + 1'b1;
          end
        end
        BREAK: begin
          if (w_rx_s) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_parity_err <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (r_deliver) begin
        if (!r_rx_valid || i_rx_ready) begin
          r_rx_data    <= r_shift;
          r_parity_err <= r_par_err;
          r_rx_valid   <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_rx_valid && i_rx_ready) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign o_rx_data    = r_rx_data;
  assign o_rx_valid   = r_rx_valid;
  assign o_parity_err = r_parity_err;
  assign o_frame_err  = r_frame_err;
  assign o_overrun    = r_overrun;
  assign o_busy       = r_busy;

endmodule
